// File: rtl/wb_pkg.sv
// Write-back stage shared types: result source selects,
// load-type encodings and the stage FSM states.
package wb_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load result extraction: picks the byte/halfword out of the
// aligned memory word, extends it, and flags misalignment.
module load_align
  import wb_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [2:0]       ldtype,
  input  logic [1:0]       addr_lo,
  input  logic [width-1:0] word,
  output logic [width-1:0] value,
  output logic             misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word[7:0];
    unique case (addr_lo)
      2'b00: w_byte = word[7:0];
      2'b01: w_byte = word[15:8];
      2'b10: w_byte = word[23:16];
      2'b11: w_byte = word[31:24];
      default: w_byte = word[7:0];
    endcase
  end

  assign w_half = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    value    = width'($signed(word[31:0]));
    misalign = 1'b0;
    unique case (ldtype)
      LD_LB:  value = width'($signed(w_byte));
      LD_LBU: value = width'(w_byte);
      LD_LH: begin
        value    = width'($signed(w_half));
        misalign = addr_lo[0];
      end
      LD_LHU: begin
        value    = width'(w_half);
        misalign = addr_lo[0];
      end
      LD_LW: begin
        value    = width'($signed(word[31:0]));
        misalign = |addr_lo;
      end
      default: begin
        value    = width'($signed(word[31:0]));
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the result, waits for load data,
// and drives a one-cycle register-file write plus forwarding.
module wb_stage
  import wb_pkg::*;
#(
  parameter int width  = 32,
  parameter int addr_w = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [addr_w-1:0] in_rd,
  input  logic [1:0]        in_wbsel,
  input  logic [2:0]        in_ldtype,
  input  logic [1:0]        in_addr_lo,
  input  logic [width-1:0]  alu_out,
  input  logic [width-1:0]  pc_plus4,
  input  logic [width-1:0]  imm,
  input  logic              dm_rsp_valid,
  input  logic [width-1:0]  dm_rsp_data,
  input  logic              flush,
  output logic              rf_we,
  output logic [addr_w-1:0] rf_waddr,
  output logic [width-1:0]  rf_wdata,
  output logic              fwd_valid,
  output logic [addr_w-1:0] fwd_rd,
  output logic [width-1:0]  fwd_data,
  output logic              ld_misalign
);

  state_e            r_state;
  logic              r_regwrite;
  logic [addr_w-1:0] r_rd;
  logic [2:0]        r_ldtype;
  logic [1:0]        r_addr_lo;
  logic [width-1:0]  r_val;
  logic              r_mis;
  logic [addr_w-1:0] r_last_addr;
  logic [width-1:0]  r_last_data;

  logic             w_accept;
  logic             w_commit;
  logic [width-1:0] w_sel;
  logic [width-1:0] w_ld_val;
  logic             w_ld_mis;

  load_align #(.width(width)) u_align (
    .ldtype   (r_ldtype),
    .addr_lo  (r_addr_lo),
    .word     (dm_rsp_data),
    .value    (w_ld_val),
    .misalign (w_ld_mis)
  );

  always_comb begin
    w_sel = '0;
    unique case (1'b1)
      (in_wbsel == WB_ALU): w_sel = alu_out;
      (in_wbsel == WB_PC4): w_sel = pc_plus4;
      (in_wbsel == WB_IMM): w_sel = imm;
      default:              w_sel = '0;
    endcase
  end

  assign in_ready = (r_state != WAIT_MEM);
  assign w_accept = in_valid && in_ready && !flush;

  // Flush kills the committing instruction in the same cycle.
  assign w_commit    = (r_state == COMMIT) && !flush;
  assign rf_we       = w_commit && r_regwrite &&
                       (r_rd != '0) && !r_mis;
  assign ld_misalign = w_commit && r_mis;

  assign rf_waddr  = rf_we ? r_rd  : r_last_addr;
  assign rf_wdata  = rf_we ? r_val : r_last_data;
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_regwrite  <= 1'b0;
      r_rd        <= '0;
      r_ldtype    <= '0;
      r_addr_lo   <= '0;
      r_val       <= '0;
      r_mis       <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      if (rf_we) begin
        r_last_addr <= r_rd;
        r_last_data <= r_val;
      end
      if (flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          WAIT_MEM: begin
            if (dm_rsp_valid) begin
              r_val   <= w_ld_val;
              r_mis   <= w_ld_mis;
              r_state <= COMMIT;
            end
          end
          default: begin
            if (w_accept) begin
              r_regwrite <= in_regwrite;
              r_rd       <= in_rd;
              r_ldtype   <= in_ldtype;
              r_addr_lo  <= in_addr_lo;
              r_val      <= w_sel;
              r_mis      <= 1'b0;
              r_state    <= (in_wbsel == WB_MEM) ?
                            WAIT_MEM : COMMIT;
            end else begin
              r_state <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for the write-back stage.
// Table-driven transactions plus flush/reset/back-to-back sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_wbsel;
  logic [2:0]  in_ldtype;
  logic [1:0]  in_addr_lo;
  logic [31:0] alu_out;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        ld_misalign;

  wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_regwrite  (in_regwrite),
    .in_rd        (in_rd),
    .in_wbsel     (in_wbsel),
    .in_ldtype    (in_ldtype),
    .in_addr_lo   (in_addr_lo),
    .alu_out      (alu_out),
    .pc_plus4     (pc_plus4),
    .imm          (imm),
    .dm_rsp_valid (dm_rsp_valid),
    .dm_rsp_data  (dm_rsp_data),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .ld_misalign  (ld_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  ld;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] src;
    logic        we;
    logic [31:0] data;
    logic        mis;
  } vec_t;

  vec_t        tv[13];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [2:0] ld,
                       input logic [1:0] lo, input logic [4:0] rd,
                       input logic rw, input logic [31:0] src);
    in_valid    = 1'b1;
    in_regwrite = rw;
    in_rd       = rd;
    in_wbsel    = sel;
    in_ldtype   = ld;
    in_addr_lo  = lo;
    alu_out     = (sel == 2'b00) ? src : 32'hDEAD_0000;
    pc_plus4    = (sel == 2'b10) ? src : 32'hDEAD_0002;
    imm         = (sel == 2'b11) ? src : 32'hDEAD_0003;
  endtask

  task automatic chk_commit(input string nm, input logic we,
                            input logic [4:0] rd,
                            input logic [31:0] data,
                            input logic mis);
    chk({nm, "_we"}, rf_we, we);
    chk({nm, "_fwdv"}, fwd_valid, we);
    chk({nm, "_mis"}, ld_misalign, mis);
    if (we) begin
      chk({nm, "_addr"}, rf_waddr, rd);
      chk({nm, "_data"}, rf_wdata, data);
      chk({nm, "_fwd"}, {fwd_rd, fwd_data}, {rd, data});
      last_addr = rd;
      last_data = data;
    end else begin
      chk({nm, "_hold"}, {rf_waddr, rf_wdata},
          {last_addr, last_data});
    end
  endtask

  task automatic do_vec(input int i);
    vec_t v;
    v = tv[i];
    @(negedge clk);
    chk($sformatf("v%0d_rdy", i), in_ready, 1'b1);
    drive(v.sel, v.ld, v.lo, v.rd, v.rw, v.src);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.sel == 2'b01) begin
      chk($sformatf("v%0d_rdy_wait", i), in_ready, 1'b0);
      chk($sformatf("v%0d_we_wait", i), rf_we, 1'b0);
      dm_rsp_valid = 1'b1;
      dm_rsp_data  = v.src;
      @(negedge clk);
      dm_rsp_valid = 1'b0;
      dm_rsp_data  = 32'h0BAD_0BAD;
    end
    #1;
    chk_commit($sformatf("v%0d", i), v.we, v.rd, v.data, v.mis);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{2'b00, 3'b000, 2'b00, 5'd5,  1'b1, 32'h0000_1234,
               1'b1, 32'h0000_1234, 1'b0};
    tv[1]  = '{2'b10, 3'b000, 2'b00, 5'd6,  1'b1, 32'h0000_0104,
               1'b1, 32'h0000_0104, 1'b0};
    tv[2]  = '{2'b11, 3'b000, 2'b00, 5'd7,  1'b1, 32'hFFFF_F000,
               1'b1, 32'hFFFF_F000, 1'b0};
    tv[3]  = '{2'b01, 3'b000, 2'b11, 5'd8,  1'b1, 32'h80AB_CDEF,
               1'b1, 32'hFFFF_FF80, 1'b0};
    tv[4]  = '{2'b01, 3'b100, 2'b00, 5'd9,  1'b1, 32'h80AB_CDEF,
               1'b1, 32'h0000_00EF, 1'b0};
    tv[5]  = '{2'b01, 3'b000, 2'b01, 5'd10, 1'b1, 32'h80AB_CDEF,
               1'b1, 32'hFFFF_FFCD, 1'b0};
    tv[6]  = '{2'b01, 3'b101, 2'b10, 5'd11, 1'b1, 32'h80AB_CDEF,
               1'b1, 32'h0000_80AB, 1'b0};
    tv[7]  = '{2'b01, 3'b001, 2'b00, 5'd12, 1'b1, 32'h80AB_CDEF,
               1'b1, 32'hFFFF_CDEF, 1'b0};
    tv[8]  = '{2'b01, 3'b010, 2'b00, 5'd13, 1'b1, 32'h80AB_CDEF,
               1'b1, 32'h80AB_CDEF, 1'b0};
    tv[9]  = '{2'b01, 3'b010, 2'b01, 5'd14, 1'b1, 32'h1111_2222,
               1'b0, 32'h0, 1'b1};
    tv[10] = '{2'b01, 3'b001, 2'b11, 5'd15, 1'b1, 32'h3333_4444,
               1'b0, 32'h0, 1'b1};
    tv[11] = '{2'b00, 3'b000, 2'b00, 5'd0,  1'b1, 32'h0000_5555,
               1'b0, 32'h0, 1'b0};
    tv[12] = '{2'b00, 3'b000, 2'b00, 5'd16, 1'b0, 32'h0000_6666,
               1'b0, 32'h0, 1'b0};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    flush        = 1'b0;
    dm_rsp_valid = 1'b0;
    dm_rsp_data  = 32'h0BAD_0BAD;
    drive(2'b00, 3'b000, 2'b00, 5'd0, 1'b0, 32'h0);
    in_valid = 1'b0;
    #3;
    chk("rst_we", rf_we, 1'b0);
    chk("rst_out", {rf_waddr, rf_wdata, fwd_rd, fwd_data}, '0);
    chk("rst_mis", ld_misalign, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", in_ready, 1'b1);

    for (int i = 0; i < 13; i++) do_vec(i);

    // back-to-back ALU ops to rd 1,2,3
    @(negedge clk);
    drive(2'b00, 3'b000, 2'b00, 5'd1, 1'b1, 32'h11);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) drive(2'b00, 3'b000, 2'b00, 5'(k + 1), 1'b1,
                       32'(17 * (k + 1)));
      else in_valid = 1'b0;
      #1;
      chk($sformatf("b2b%0d_rdy", k), in_ready, 1'b1);
      chk_commit($sformatf("b2b%0d", k), 1'b1, 5'(k), 32'(17 * k), 1'b0);
    end
    @(negedge clk);
    #1;
    chk("b2b_end_we", rf_we, 1'b0);

    // flush in WAIT_MEM together with response and in_valid
    @(negedge clk);
    drive(2'b01, 3'b010, 2'b00, 5'd20, 1'b1, 32'h0);
    @(negedge clk);
    drive(2'b00, 3'b000, 2'b00, 5'd21, 1'b1, 32'h7777);
    flush        = 1'b1;
    dm_rsp_valid = 1'b1;
    dm_rsp_data  = 32'h1234_5678;
    #1;
    chk("fw_we", rf_we, 1'b0);
    @(negedge clk);
    flush        = 1'b0;
    dm_rsp_valid = 1'b0;
    in_valid     = 1'b0;
    #1;
    chk("fw_rdy", in_ready, 1'b1);
    chk_commit("fw_after", 1'b0, 5'd0, 32'h0, 1'b0);

    // flush during COMMIT suppresses the write
    @(negedge clk);
    drive(2'b00, 3'b000, 2'b00, 5'd22, 1'b1, 32'h8888);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    chk_commit("fc", 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fc_after_we", rf_we, 1'b0);

    // reset while waiting for a load, then a stray response
    @(negedge clk);
    drive(2'b01, 3'b000, 2'b00, 5'd23, 1'b1, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rw_we", {rf_we, fwd_valid, ld_misalign}, 3'b000);
    chk("rw_out", {rf_waddr, rf_wdata, fwd_rd, fwd_data}, '0);
    last_addr = '0;
    last_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rw_rdy", in_ready, 1'b1);
    dm_rsp_valid = 1'b1;
    dm_rsp_data  = 32'h80AB_CDEF;
    @(negedge clk);
    dm_rsp_valid = 1'b0;
    #1;
    chk_commit("rw_stray", 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    chk_commit("rw_stray2", 1'b0, 5'd0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter width, default 32, meaning register data width; legal values 32 and 64.
REQ-002 The block SHALL have parameter addr_w, default 5, meaning register-file address width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  upstream instruction valid.
REQ-006 Port in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 Port in_regwrite  input  1  instruction writes the register file.
REQ-008 Port in_rd  input  addr_w  destination register.
REQ-009 Port in_wbsel  input  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
REQ-010 Port in_ldtype  input  3  load type, funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 Port in_addr_lo  input  2  low two bits of load address.
REQ-012 Ports alu_out, pc_plus4, imm  input  width each  candidate write-back values.
REQ-013 Ports dm_rsp_valid  input  1 and dm_rsp_data  input  width: data-memory response, aligned word in bits [31:0].
REQ-014 Port flush  input  1  kill the pending instruction.
REQ-015 Ports rf_we  output  1, rf_waddr  output  addr_w, rf_wdata  output  width: register-file write.
REQ-016 Ports fwd_valid  output  1, fwd_rd  output  addr_w, fwd_data  output  width: forwarding bus.
REQ-017 Port ld_misalign  output  1  one-cycle pulse on a misaligned LH/LHU/LW.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT_MEM, COMMIT.
REQ-019 Accept SHALL occur when in_valid && in_ready; in_ready SHALL be 1 in IDLE and COMMIT and 0 in WAIT_MEM.
REQ-020 On accept with in_wbsel != 01 the selected value SHALL be registered and the FSM SHALL go to COMMIT (latency 1 cycle accept-to-rf_we).
REQ-021 On accept with in_wbsel == 01 the FSM SHALL go to WAIT_MEM and remain there until dm_rsp_valid, then latch the aligned load result and go to COMMIT.
REQ-022 A response arriving on the cycle after accept SHALL give rf_we 2 cycles after accept; no response SHALL mean indefinite wait.
REQ-023 Load alignment: LB/LBU select byte in_addr_lo; LH/LHU select halfword in_addr_lo[1]; LB/LH sign-extend and LBU/LHU zero-extend to width; LW sign-extends bits [31:0] to width.
REQ-024 LH/LHU with in_addr_lo[0]=1, or LW with in_addr_lo != 00, SHALL pulse ld_misalign in the COMMIT cycle and suppress rf_we.
REQ-025 In COMMIT, rf_we SHALL be in_regwrite (registered) && rd != 0 && !misaligned, for exactly one cycle.
REQ-026 A new accept during COMMIT SHALL be allowed, giving back-to-back non-load throughput of one per cycle.
REQ-027 With no accept in COMMIT, the next state SHALL be IDLE.
REQ-028 fwd_valid SHALL equal rf_we; fwd_rd/fwd_data SHALL equal rf_waddr/rf_wdata in the same cycle.
REQ-029 flush SHALL take priority over all events: in WAIT_MEM or COMMIT it SHALL force IDLE, suppress rf_we that cycle and ignore a simultaneous in_valid.
REQ-030 dm_rsp_valid outside WAIT_MEM SHALL be ignored.
REQ-031 rf_waddr/rf_wdata SHALL hold their last values when rf_we is 0.

Reset
REQ-032 Asserting rst_n low SHALL immediately force IDLE, rf_we=0, fwd_valid=0, ld_misalign=0, rf_waddr=0, rf_wdata=0, fwd_rd=0, fwd_data=0.
REQ-033 Reset mid-operation, including WAIT_MEM, SHALL discard the pending instruction with no write.
REQ-034 After reset release, in_ready SHALL be 1 on the first clock edge.

Structure
REQ-035 Package wb_pkg SHALL hold the wbsel encodings, the load-type encodings and the FSM state enum.
REQ-036 Sub-module load_align SHALL be purely combinational: inputs ldtype, addr_lo, word; outputs value and misalign.

Verification
REQ-037 ALU: in_wbsel=00, rd=5, alu_out=0x0000_1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234.
REQ-038 LB: addr_lo=11, response 0x80AB_CDEF two cycles later -> rf_wdata=0xFFFF_FF80, in_ready=0 while waiting.
REQ-039 LHU: addr_lo=10, response 0x80AB_CDEF -> rf_wdata=0x0000_80AB; LW with addr_lo=01 -> ld_misalign=1, rf_we=0.
REQ-040 Back-to-back: three ALU ops on consecutive cycles to rd=1,2,3 -> three consecutive rf_we pulses in order; rd=0 op -> rf_we=0.
REQ-041 Flush in WAIT_MEM coinciding with dm_rsp_valid -> no write, state IDLE, in_ready=1 next cycle.
REQ-042 rst_n low in WAIT_MEM -> all outputs 0 immediately; a later stray dm_rsp_valid produces no write.
